// File: rtl/clock_ratio_monitor_pkg.sv
// rtl/clock_ratio_monitor_pkg.sv - shared types and widths for the divided-clock ratio monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } mon_state_t;

    localparam int CNT_MAX = 63;
    localparam int RATIO_W = 6;
    localparam int MEAS_W  = 7;

endpackage

// File: rtl/clock_ratio_monitor_if.sv
// rtl/clock_ratio_monitor_if.sv - control inputs and measurement results of the ratio monitor
interface clock_ratio_monitor_if;
    import clk_mon_pkg::*;

    logic               monitor_en;
    logic               sampled_clk;
    logic [RATIO_W-1:0] expected_ratio;
    logic [RATIO_W-1:0] high_cycles;
    logic [RATIO_W-1:0] low_cycles;
    logic [MEAS_W-1:0]  measured_ratio;
    logic               ratio_valid;
    logic               ratio_match;
    logic               lock;
    logic               timeout;

    modport master (
        output monitor_en,
        output sampled_clk,
        output expected_ratio,
        input  high_cycles,
        input  low_cycles,
        input  measured_ratio,
        input  ratio_valid,
        input  ratio_match,
        input  lock,
        input  timeout
    );

    modport slave (
        input  monitor_en,
        input  sampled_clk,
        input  expected_ratio,
        output high_cycles,
        output low_cycles,
        output measured_ratio,
        output ratio_valid,
        output ratio_match,
        output lock,
        output timeout
    );

endinterface

// File: rtl/clock_ratio_monitor_edge_detect.sv
// rtl/clock_ratio_monitor_edge_detect.sv - one-flop edge detector for signals already in the clk domain
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// rtl/clock_ratio_monitor.sv - measures high/low/period of a divided clock and tracks ratio lock
module clock_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = $clog2(CNT_MAX + 1)
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    clock_ratio_monitor_if.slave mon
);

    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LIM  = '1;
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

    mon_state_t state_q, state_d;

    logic [CNT_W-1:0] hi_cnt, hi_d;
    logic [CNT_W-1:0] lo_cnt, lo_d;
    logic [CNT_W-1:0] wait_cnt, wait_d;
    logic [3:0]       match_cnt, match_cnt_d;

    logic [CNT_W-1:0] high_q, low_q;
    logic [SUM_W-1:0] meas_q;
    logic             valid_q, match_q, lock_q, timeout_q;

    logic rise, fall;
    logic do_latch, do_timeout;
    logic [CNT_W-1:0] phase_diff;
    logic [SUM_W-1:0] period_sum;
    logic             period_match;

    edge_detect u_edge (
        .clk   (ref_clk),
        .reset (reset),
        .d     (mon.sampled_clk),
        .rise  (rise),
        .fall  (fall)
    );

    // Odd ratios put the extra cycle in the high phase, so high - low must be 0 or 1.
    assign phase_diff   = hi_cnt - lo_cnt;
    assign period_sum   = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign period_match = (period_sum == SUM_W'(mon.expected_ratio))
                          && ((phase_diff == '0) || (phase_diff == CNT_W'(1)));

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_cnt;
        lo_d       = lo_cnt;
        wait_d     = wait_cnt;
        do_latch   = 1'b0;
        do_timeout = 1'b0;

        if (!mon.monitor_en) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                    wait_d  = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        hi_d    = CNT_W'(1);
                        wait_d  = '0;
                    end else if (wait_cnt == CNT_LIM) begin
                        do_timeout = 1'b1;
                        wait_d     = '0;
                    end else begin
                        wait_d = wait_cnt + 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_d = MEAS_LOW;
                        lo_d    = CNT_W'(1);
                    end else if (hi_cnt == CNT_LIM) begin
                        do_timeout = 1'b1;
                        state_d    = WAIT_RISE;
                        wait_d     = '0;
                    end else if (mon.sampled_clk) begin
                        hi_d = hi_cnt + 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        do_latch = 1'b1;
                        state_d  = MEAS_HIGH;
                        hi_d     = CNT_W'(1);
                    end else if (lo_cnt == CNT_LIM) begin
                        do_timeout = 1'b1;
                        state_d    = WAIT_RISE;
                        wait_d     = '0;
                    end else if (!mon.sampled_clk) begin
                        lo_d = lo_cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        match_cnt_d = match_cnt;
        if (do_latch) begin
            if (!period_match) begin
                match_cnt_d = '0;
            end else if (match_cnt != LOCK_MAX) begin
                match_cnt_d = match_cnt + 1'b1;
            end
        end
        if (do_timeout || !mon.monitor_en) begin
            match_cnt_d = '0;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            wait_cnt  <= '0;
            match_cnt <= '0;
            high_q    <= '0;
            low_q     <= '0;
            meas_q    <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            hi_cnt    <= hi_d;
            lo_cnt    <= lo_d;
            wait_cnt  <= wait_d;
            match_cnt <= match_cnt_d;
            valid_q   <= do_latch;
            timeout_q <= do_timeout;
            lock_q    <= (match_cnt_d == LOCK_MAX);
            if (do_latch) begin
                high_q  <= hi_cnt;
                low_q   <= lo_cnt;
                meas_q  <= period_sum;
                match_q <= period_match;
            end
        end
    end

    assign mon.high_cycles    = RATIO_W'(high_q);
    assign mon.low_cycles     = RATIO_W'(low_q);
    assign mon.measured_ratio = MEAS_W'(meas_q);
    assign mon.ratio_valid    = valid_q;
    assign mon.ratio_match    = match_q;
    assign mon.lock           = lock_q;
    assign mon.timeout        = timeout_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb/tb_clock_ratio_monitor.sv - directed self-checking bench for clock_ratio_monitor
module tb_clock_ratio_monitor;

    logic ref_clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   t_ref;

    logic [5:0] q_hi[$];
    logic [5:0] q_lo[$];
    logic [6:0] q_meas[$];
    logic       q_match[$];
    logic       q_lock[$];
    int         q_to[$];

    clock_ratio_monitor_if bus ();

    clock_ratio_monitor #(
        .LOCK_COUNT (4),
        .CNT_W      (6)
    ) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .mon     (bus.slave)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
        cyc++;
        if (bus.ratio_valid === 1'b1) begin
            q_hi.push_back(bus.high_cycles);
            q_lo.push_back(bus.low_cycles);
            q_meas.push_back(bus.measured_ratio);
            q_match.push_back(bus.ratio_match);
            q_lock.push_back(bus.lock);
        end
        if (bus.timeout === 1'b1) q_to.push_back(cyc);
    endtask

    task automatic clear_log();
        q_hi.delete();
        q_lo.delete();
        q_meas.delete();
        q_match.delete();
        q_lock.delete();
        q_to.delete();
    endtask

    task automatic run_period(input int h, input int l);
        for (int i = 0; i < h; i++) begin
            bus.sampled_clk = 1'b1;
            tick();
        end
        for (int i = 0; i < l; i++) begin
            bus.sampled_clk = 1'b0;
            tick();
        end
    endtask

    task automatic close_period();
        bus.sampled_clk = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_valid(input int k, input int hi, input int lo, input int m, input int lk);
        chk($sformatf("v%0d_high", k), q_hi[k], hi);
        chk($sformatf("v%0d_low", k), q_lo[k], lo);
        chk($sformatf("v%0d_meas", k), q_meas[k], hi + lo);
        chk($sformatf("v%0d_match", k), q_match[k], m);
        chk($sformatf("v%0d_lock", k), q_lock[k], lk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_high"}, bus.high_cycles, 0);
        chk({tag, "_low"}, bus.low_cycles, 0);
        chk({tag, "_meas"}, bus.measured_ratio, 0);
        chk({tag, "_valid"}, bus.ratio_valid, 0);
        chk({tag, "_match"}, bus.ratio_match, 0);
        chk({tag, "_lock"}, bus.lock, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
    endtask

    task automatic restart(input int ratio);
        bus.monitor_en  = 1'b0;
        bus.sampled_clk = 1'b0;
        tick();
        tick();
        chk("disable_lock", bus.lock, 0);
        bus.expected_ratio = 6'(ratio);
        bus.monitor_en     = 1'b1;
        tick();
        clear_log();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.monitor_en     = 1'b0;
        bus.sampled_clk    = 1'b0;
        bus.expected_ratio = 6'd0;
        repeat (3) tick();
        reset = 1'b0;
        check_zero_outputs("reset");

        // ratio 4: 2 high / 2 low, lock on the 4th result
        bus.expected_ratio = 6'd4;
        bus.monitor_en     = 1'b1;
        tick();
        clear_log();
        repeat (6) run_period(2, 2);
        close_period();
        chk("r4_count", q_hi.size(), 6);
        for (int k = 0; k < 6; k++) check_valid(k, 2, 2, 1, (k >= 3) ? 1 : 0);

        // ratio 5: odd ratio puts the extra cycle high
        restart(5);
        repeat (5) run_period(3, 2);
        close_period();
        chk("r5_count", q_hi.size(), 5);
        for (int k = 0; k < 5; k++) check_valid(k, 3, 2, 1, (k >= 3) ? 1 : 0);

        // ratio change 6 -> 8 while locked, then reprogram expected_ratio
        restart(6);
        repeat (5) run_period(3, 3);
        run_period(4, 4);
        bus.sampled_clk = 1'b1;
        tick();
        bus.expected_ratio = 6'd8;
        tick();
        tick();
        tick();
        bus.sampled_clk = 1'b0;
        repeat (4) tick();
        repeat (4) run_period(4, 4);
        close_period();
        chk("chg_count", q_hi.size(), 11);
        for (int k = 0; k < 5; k++) check_valid(k, 3, 3, 1, (k >= 3) ? 1 : 0);
        check_valid(5, 4, 4, 0, 0);
        for (int k = 6; k < 11; k++) check_valid(k, 4, 4, 1, (k >= 9) ? 1 : 0);
        chk("chg_no_timeout", q_to.size(), 0);

        // flat line: timeout every 64 cycles from WAIT_RISE
        restart(8);
        t_ref = cyc;
        bus.sampled_clk = 1'b0;
        repeat (200) tick();
        chk("flat_to_count", q_to.size(), 3);
        chk("flat_to0", q_to[0] - t_ref, 64);
        chk("flat_to1", q_to[1] - q_to[0], 64);
        chk("flat_to2", q_to[2] - q_to[1], 64);
        chk("flat_no_valid", q_hi.size(), 0);
        chk("flat_lock", bus.lock, 0);

        // saturation: high phase too long, previous results retained
        clear_log();
        bus.sampled_clk = 1'b1;
        tick();
        t_ref = cyc;
        repeat (69) tick();
        chk("sat_to_count", q_to.size(), 1);
        chk("sat_to_time", q_to[0] - t_ref, 63);
        chk("sat_no_valid", q_hi.size(), 0);
        chk("sat_high_kept", bus.high_cycles, 4);
        chk("sat_low_kept", bus.low_cycles, 4);
        chk("sat_meas_kept", bus.measured_ratio, 8);
        chk("sat_lock", bus.lock, 0);
        bus.sampled_clk = 1'b0;
        repeat (3) tick();
        run_period(3, 3);
        close_period();
        chk("sat_rearm_count", q_hi.size(), 1);
        check_valid(0, 3, 3, 0, 0);

        // reset in MEAS_LOW, then a fresh two-rise measurement
        bus.sampled_clk = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero_outputs("midrst");
        bus.expected_ratio = 6'd6;
        tick();
        clear_log();
        run_period(3, 3);
        chk("midrst_first_rise", q_hi.size(), 0);
        close_period();
        chk("midrst_count", q_hi.size(), 1);
        check_valid(0, 3, 3, 1, 0);

        // monitor_en dropping on the latch rise suppresses the result
        bus.sampled_clk = 1'b1;
        tick();
        run_period(0, 3);
        bus.monitor_en  = 1'b0;
        bus.sampled_clk = 1'b1;
        tick();
        tick();
        chk("drop_en_count", q_hi.size(), 1);
        chk("drop_en_valid", bus.ratio_valid, 0);
        chk("drop_en_lock", bus.lock, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
